// File: rtl/huff_frame_sched.sv
// huff_frame_sched: frames a contiguous burst of gray samples into a huffman
// core, clears the core before each frame, waits (with timeouts) for the
// core's count and code results, and holds them on a result handshake.
//
// Handshakes: a beat moves on a rising clk edge when valid and ready are both
// high; valid never waits for ready and ready is decoded from state only.
module huff_frame_sched #(
  parameter int FRAME_LEN  = 100,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        core_rst,
  output logic        core_gray_valid,
  output logic [7:0]  core_gray_data,
  input  logic        core_cnt_valid,
  input  logic [47:0] core_cnt,
  input  logic        core_code_valid,
  input  logic [47:0] core_hc,
  input  logic [47:0] core_m,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] out_cnt,
  output logic [47:0] out_hc,
  output logic [47:0] out_m,
  output logic [15:0] frame_cnt,
  output logic        err,
  output logic [1:0]  err_code,
  input  logic        clr_err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLR       = 3'd1,
    FEED      = 3'd2,
    WAIT_CNT  = 3'd3,
    WAIT_CODE = 3'd4,
    HOLD      = 3'd5,
    ERR       = 3'd6
  } state_e;

  localparam logic [7:0]  FRAME_LAST = 8'(FRAME_LEN - 1);
  localparam logic [3:0]  CLR_LAST   = 4'(CLR_CYCLES - 1);
  localparam logic [11:0] TO_LAST    = 12'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [3:0]  clr_cnt_q, clr_cnt_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic [11:0] wait_cnt_q, wait_cnt_d;
  logic        gray_valid_q, gray_valid_d;
  logic [7:0]  gray_data_q, gray_data_d;
  logic [47:0] out_cnt_q, out_cnt_d;
  logic [47:0] out_hc_q, out_hc_d;
  logic [47:0] out_m_q, out_m_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        accept;

  // A sample is taken only in FEED, where in_ready is high.
  assign accept = in_valid && (state_q == FEED);

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      clr_cnt_q    <= '0;
      beat_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      gray_valid_q <= 1'b0;
      gray_data_q  <= '0;
      out_cnt_q    <= '0;
      out_hc_q     <= '0;
      out_m_q      <= '0;
      frame_cnt_q  <= '0;
      err_code_q   <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      gray_valid_q <= gray_valid_d;
      gray_data_q  <= gray_data_d;
      out_cnt_q    <= out_cnt_d;
      out_hc_q     <= out_hc_d;
      out_m_q      <= out_m_d;
      frame_cnt_q  <= frame_cnt_d;
      err_code_q   <= err_code_d;
    end
  end

  // Next-state decision; a strobe arriving on the last wait cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (in_valid) state_d = CLR;
      CLR:       if (clr_cnt_q == CLR_LAST) state_d = FEED;
      FEED: begin
        if (in_valid) begin
          if (beat_cnt_q == FRAME_LAST) state_d = WAIT_CNT;
        end else if (beat_cnt_q != 8'd0) begin
          state_d = ERR;
        end
      end
      WAIT_CNT: begin
        if (core_cnt_valid && core_code_valid) state_d = HOLD;
        else if (core_cnt_valid)               state_d = WAIT_CODE;
        else if (wait_cnt_q == TO_LAST)        state_d = ERR;
      end
      WAIT_CODE: begin
        if (core_code_valid)            state_d = HOLD;
        else if (wait_cnt_q == TO_LAST) state_d = ERR;
      end
      HOLD:      if (out_ready) state_d = IDLE;
      ERR:       if (clr_err) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Counters, sample pipeline, result capture and error cause.
  always_comb begin
    clr_cnt_d    = '0;
    beat_cnt_d   = '0;
    wait_cnt_d   = '0;
    gray_valid_d = accept;
    gray_data_d  = accept ? in_data : gray_data_q;
    out_cnt_d    = out_cnt_q;
    out_hc_d     = out_hc_q;
    out_m_d      = out_m_q;
    frame_cnt_d  = frame_cnt_q;
    err_code_d   = err_code_q;

    // Counters run only while staying in their state, so entry sees zero.
    if (state_q == CLR && state_d == CLR) clr_cnt_d = clr_cnt_q + 4'd1;
    if (state_q == FEED && state_d == FEED)
      beat_cnt_d = accept ? beat_cnt_q + 8'd1 : beat_cnt_q;
    if ((state_q == WAIT_CNT || state_q == WAIT_CODE) && state_d == state_q)
      wait_cnt_d = wait_cnt_q + 12'd1;

    if (state_q == WAIT_CNT && core_cnt_valid) out_cnt_d = core_cnt;
    if ((state_q == WAIT_CNT && core_cnt_valid && core_code_valid) ||
        (state_q == WAIT_CODE && core_code_valid)) begin
      out_hc_d = core_hc;
      out_m_d  = core_m;
    end

    if (state_q == HOLD && out_ready) frame_cnt_d = frame_cnt_q + 16'd1;

    if (state_q != ERR && state_d == ERR) begin
      case (state_q)
        FEED:      err_code_d = 2'd1;
        WAIT_CNT:  err_code_d = 2'd2;
        default:   err_code_d = 2'd3;
      endcase
    end else if (state_q == ERR && state_d != ERR) begin
      err_code_d = 2'd0;
    end
  end

  // Moore outputs decoded from state only.
  always_comb begin
    in_ready  = 1'b0;
    core_rst  = 1'b0;
    out_valid = 1'b0;
    err       = 1'b0;
    case (state_q)
      IDLE, CLR: core_rst = 1'b1;
      FEED:      in_ready = 1'b1;
      HOLD:      out_valid = 1'b1;
      ERR: begin
        core_rst = 1'b1;
        err      = 1'b1;
      end
      default: ;
    endcase
  end

  assign core_gray_valid = gray_valid_q;
  assign core_gray_data  = gray_data_q;
  assign out_cnt         = out_cnt_q;
  assign out_hc          = out_hc_q;
  assign out_m           = out_m_q;
  assign frame_cnt       = frame_cnt_q;
  assign err_code        = err_code_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_huff_frame_sched.sv
// Testbench for huff_frame_sched: drives gray frames and core responses,
// scoreboards the sample stream and the frame results.
//
// Handshakes: a beat moves on a rising clk edge when valid and ready are both
// high; the bench drives inputs 1 time unit after posedge and samples outputs
// on negedge.
module tb_huff_frame_sched;
  localparam int FRAME_LEN  = 100;
  localparam int CLR_CYCLES = 2;
  localparam int TIMEOUT    = 20;

  localparam logic [2:0] S_IDLE = 3'd0, S_CLR = 3'd1, S_FEED = 3'd2,
    S_WCNT = 3'd3, S_WCODE = 3'd4, S_HOLD = 3'd5, S_ERR = 3'd6;

  logic        clk, reset;
  logic        in_valid, in_ready;
  logic [7:0]  in_data;
  logic        core_rst, core_gray_valid;
  logic [7:0]  core_gray_data;
  logic        core_cnt_valid, core_code_valid;
  logic [47:0] core_cnt, core_hc, core_m;
  logic        out_valid, out_ready;
  logic [47:0] out_cnt, out_hc, out_m;
  logic [15:0] frame_cnt;
  logic        err, clr_err;
  logic [1:0]  err_code;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int gray_pops = 0;
  logic [7:0]   exp_q[$];
  logic [143:0] res_q[$];
  logic [15:0]  exp_frames;
  logic         acc_pending, acc_prev;

  huff_frame_sched #(.FRAME_LEN(FRAME_LEN), .CLR_CYCLES(CLR_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_rst(core_rst), .core_gray_valid(core_gray_valid), .core_gray_data(core_gray_data),
    .core_cnt_valid(core_cnt_valid), .core_cnt(core_cnt),
    .core_code_valid(core_code_valid), .core_hc(core_hc), .core_m(core_m),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_cnt(out_cnt), .out_hc(out_hc), .out_m(out_m),
    .frame_cnt(frame_cnt), .err(err), .err_code(err_code), .clr_err(clr_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [143:0] got, input logic [143:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset values, checked immediately after assertion (no clock edge needed).
  task automatic apply_reset();
    reset = 1'b0;
    #1;
    exp_q.delete();
    res_q.delete();
    acc_prev   = 1'b0;
    exp_frames = '0;
    check_eq("rst_state", dbg_state, S_IDLE);
    check_eq("rst_core_rst", core_rst, 1'b1);
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_gray_valid", core_gray_valid, 1'b0);
    check_eq("rst_gray_data", core_gray_data, 8'd0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_bus", {out_cnt, out_hc, out_m}, 144'd0);
    check_eq("rst_frame_cnt", frame_cnt, 16'd0);
    check_eq("rst_err", {err, err_code}, 3'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) acc_pending = reset && in_valid && in_ready;

  always @(posedge clk) begin
    if (acc_pending) exp_q.push_back(in_data);
    acc_prev = acc_pending;
  end

  // Every accepted beat must show up exactly one cycle later, in order.
  always @(negedge clk) begin
    if (reset) begin
      check_eq("gray_valid_timing", core_gray_valid, acc_prev);
      if (core_gray_valid) begin
        check_eq("gray_q_avail", 144'(exp_q.size() != 0), 144'd1);
        if (exp_q.size() != 0) begin
          check_eq("gray_data", core_gray_data, exp_q.pop_front());
          gray_pops++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      check_eq("res_q_avail", 144'(res_q.size() != 0), 144'd1);
      if (res_q.size() != 0) check_eq("out_bus", {out_cnt, out_hc, out_m}, res_q.pop_front());
    end
  end

  // ---------------- drivers ----------------
  // Feeds one frame; stops early after beat gap_at (underrun) or rst_at (reset).
  task automatic send_frame(input bit seq, input int gap_at, input int rst_at, output int lead);
    int i;
    int cyc;
    logic acc;
    i = 0;
    cyc = 0;
    lead = 0;
    in_valid = 1'b1;
    in_data = seq ? 8'd0 : 8'($urandom_range(0, 255));
    while (i < FRAME_LEN && cyc < 500) begin
      @(negedge clk);
      acc = in_ready;
      if (!acc && i == 0) lead++;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        i++;
        in_data = seq ? 8'(i) : 8'($urandom_range(0, 255));
        if (i == gap_at || i == rst_at) break;
      end
    end
    in_valid = 1'b0;
    if (gap_at == 0 && rst_at == 0) check_eq("feed_beats", i, FRAME_LEN);
  endtask

  task automatic rand48(output logic [47:0] v);
    v = {16'($urandom), 32'($urandom)};
  endtask

  // Core answers with a count then a code strobe (or both at once).
  task automatic core_respond(input int cnt_dly, input int code_dly, input bit simul,
                              output logic [143:0] res);
    logic [47:0] c, h, m;
    rand48(c);
    rand48(h);
    rand48(m);
    res = {c, h, m};
    check_eq("wcnt_state", dbg_state, S_WCNT);
    check_eq("wcnt_in_ready", in_ready, 1'b0);
    tick(cnt_dly);
    core_cnt = c;
    core_cnt_valid = 1'b1;
    if (simul) begin
      core_hc = h;
      core_m = m;
      core_code_valid = 1'b1;
      res_q.push_back(res);
    end
    tick(1);
    core_cnt_valid = 1'b0;
    core_code_valid = 1'b0;
    if (!simul) begin
      check_eq("wcode_state", dbg_state, S_WCODE);
      tick(code_dly);
      core_hc = h;
      core_m = m;
      core_code_valid = 1'b1;
      res_q.push_back(res);
      tick(1);
      core_code_valid = 1'b0;
    end
    check_eq("hold_state", dbg_state, S_HOLD);
    check_eq("hold_out_valid", out_valid, 1'b1);
    check_eq("hold_out_bus", {out_cnt, out_hc, out_m}, res);
  endtask

  task automatic clear_error();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check_eq("clr_state", dbg_state, S_IDLE);
    check_eq("clr_err_flags", {err, err_code}, 3'd0);
    check_eq("clr_frame_cnt", frame_cnt, exp_frames);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lead;
    logic [143:0] res;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    core_cnt_valid = 1'b0;
    core_code_valid = 1'b0;
    core_cnt = '0;
    core_hc = '0;
    core_m = '0;
    out_ready = 1'b1;
    clr_err = 1'b0;
    acc_prev = 1'b0;
    acc_pending = 1'b0;
    #2;
    apply_reset();

    // Nominal frame: beats 0..99, count after 5 cycles, code 10 later.
    gray_pops = 0;
    send_frame(1'b1, 0, 0, lead);
    check_eq("clr_lead_cycles", lead, 1 + CLR_CYCLES);
    core_respond(5, 10, 1'b0, res);
    tick(1);
    exp_frames++;
    check_eq("nom_idle", dbg_state, S_IDLE);
    check_eq("nom_frame_cnt", frame_cnt, exp_frames);
    check_eq("nom_gray_pulses", gray_pops, FRAME_LEN);
    // Strobes in IDLE must not disturb the held results.
    core_cnt_valid = 1'b1;
    core_code_valid = 1'b1;
    core_cnt = ~core_cnt;
    core_hc = ~core_hc;
    tick(1);
    core_cnt_valid = 1'b0;
    core_code_valid = 1'b0;
    check_eq("idle_strobe_ignored", {out_cnt, out_hc, out_m}, res);

    // Underrun at beat 50.
    send_frame(1'b0, 50, 0, lead);
    tick(1);
    check_eq("under_state", dbg_state, S_ERR);
    check_eq("under_err", {err, err_code}, {1'b1, 2'd1});
    check_eq("under_core_rst", core_rst, 1'b1);
    check_eq("under_ready_valid", {in_ready, out_valid}, 2'b00);
    tick(3);
    check_eq("under_sticky", {err, err_code}, {1'b1, 2'd1});
    clear_error();

    // Count timeout: no count strobe at all.
    send_frame(1'b0, 0, 0, lead);
    tick(TIMEOUT - 1);
    check_eq("cnt_to_before", dbg_state, S_WCNT);
    tick(1);
    check_eq("cnt_to_state", dbg_state, S_ERR);
    check_eq("cnt_to_code", err_code, 2'd2);
    clear_error();

    // Code timeout: count arrives, code never does.
    send_frame(1'b0, 0, 0, lead);
    core_cnt = 48'h0000_1234_5678;
    core_cnt_valid = 1'b1;
    tick(1);
    core_cnt_valid = 1'b0;
    check_eq("code_to_entry", dbg_state, S_WCODE);
    tick(TIMEOUT - 1);
    check_eq("code_to_before", dbg_state, S_WCODE);
    tick(1);
    check_eq("code_to_state", dbg_state, S_ERR);
    check_eq("code_to_code", err_code, 2'd3);
    check_eq("code_to_frame_cnt", frame_cnt, exp_frames);
    clear_error();

    // Simultaneous strobes in WAIT_CNT go straight to HOLD.
    send_frame(1'b0, 0, 0, lead);
    core_respond(3, 0, 1'b1, res);
    tick(1);
    exp_frames++;
    check_eq("simul_frame_cnt", frame_cnt, exp_frames);

    // Back-pressure: 30 cycles of out_ready low, next frame requested meanwhile.
    out_ready = 1'b0;
    send_frame(1'b0, 0, 0, lead);
    core_respond(2, 4, 1'b0, res);
    in_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      core_cnt_valid = (k == 7);
      core_code_valid = (k == 7);
      core_cnt = ~res[143:96];
      tick(1);
      check_eq("bp_out_valid", out_valid, 1'b1);
      check_eq("bp_out_bus", {out_cnt, out_hc, out_m}, res);
      check_eq("bp_in_ready", in_ready, 1'b0);
      check_eq("bp_state", dbg_state, S_HOLD);
    end
    core_cnt_valid = 1'b0;
    core_code_valid = 1'b0;
    out_ready = 1'b1;
    tick(1);
    exp_frames++;
    check_eq("bp_xfer_state", dbg_state, S_IDLE);
    check_eq("bp_frame_cnt", frame_cnt, exp_frames);
    send_frame(1'b0, 0, 0, lead);
    core_respond(1, 1, 1'b0, res);
    tick(1);
    exp_frames++;
    check_eq("bp_second_frame_cnt", frame_cnt, exp_frames);

    // Reset at beat 40, then a normal frame.
    send_frame(1'b0, 0, 40, lead);
    apply_reset();
    send_frame(1'b0, 0, 0, lead);
    core_respond(5, 10, 1'b0, res);
    tick(1);
    exp_frames++;
    check_eq("post_rst_frame_cnt", frame_cnt, exp_frames);
    tick(2);
    check_eq("end_gray_q_empty", exp_q.size(), 0);
    check_eq("end_res_q_empty", res_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
